// File: rtl/iir_biquad_mac_sequencer.sv
// Direct-form-I biquad sequencer: five taps share one external 4x4 signed multiplier,
// one tap per cycle, then the accumulator is quantised, saturated and registered out.
module iir_biquad_mac_sequencer #(
    parameter int DW    = 4,
    parameter int ACC_W = 12,
    parameter int FRAC  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [DW-1:0]   x_in,
    input  logic signed [DW-1:0]   b0,
    input  logic signed [DW-1:0]   b1,
    input  logic signed [DW-1:0]   b2,
    input  logic signed [DW-1:0]   a1,
    input  logic signed [DW-1:0]   a2,
    output logic signed [DW-1:0]   mul_a,
    output logic signed [DW-1:0]   mul_b,
    input  logic signed [2*DW-1:0] mul_p,
    output logic signed [DW-1:0]   y_out,
    output logic                   out_valid,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((2 ** (DW - 1)) - 1);
    localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-(2 ** (DW - 1)));

    state_t                  state_q, state_d;
    logic [2:0]              tap_q, tap_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [DW-1:0]    x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
    logic signed [DW-1:0]    y1_q, y1_d, y2_q, y2_d;
    logic signed [DW-1:0]    b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
    logic signed [DW-1:0]    a1_q, a1_d, a2_q, a2_d;
    logic signed [DW-1:0]    y_out_q, y_out_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [DW-1:0]    y_sat;

    // Arithmetic shift drops the Q2.2 fraction, truncating toward -inf.
    function automatic logic signed [ACC_W-1:0] shift_frac(input logic signed [ACC_W-1:0] a);
        return a >>> FRAC;
    endfunction

    function automatic logic signed [DW-1:0] sat_dw(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] c;
        c = v;
        if (v > Y_MAX) c = Y_MAX;
        else if (v < Y_MIN) c = Y_MIN;
        return c[DW-1:0];
    endfunction

    assign prod_ext  = ACC_W'(mul_p);
    assign y_sat     = sat_dw(shift_frac(acc_q));
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign y_out     = y_out_q;
    assign out_valid = out_valid_q;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (state_q == MAC) begin
            case (tap_q)
                3'd0:    begin mul_a = b0_q; mul_b = x0_q; end
                3'd1:    begin mul_a = b1_q; mul_b = x1_q; end
                3'd2:    begin mul_a = b2_q; mul_b = x2_q; end
                3'd3:    begin mul_a = a1_q; mul_b = y1_q; end
                3'd4:    begin mul_a = a2_q; mul_b = y2_q; end
                default: begin mul_a = '0;   mul_b = '0;   end
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        acc_d       = acc_q;
        x0_d        = x0_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        y1_d        = y1_q;
        y2_d        = y2_q;
        b0_d        = b0_q;
        b1_d        = b1_q;
        b2_d        = b2_q;
        a1_d        = a1_q;
        a2_d        = a2_q;
        y_out_d     = y_out_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x0_d    = x_in;
                    b0_d    = b0;
                    b1_d    = b1;
                    b2_d    = b2;
                    a1_d    = a1;
                    a2_d    = a2;
                    acc_d   = '0;
                    tap_d   = 3'd0;
                    state_d = MAC;
                end
            end
            MAC: begin
                // Feed-forward taps add, feedback taps subtract.
                if (tap_q < 3'd3) acc_d = acc_q + prod_ext;
                else              acc_d = acc_q - prod_ext;
                if (tap_q == 3'd4) state_d = OUT;
                else               tap_d   = tap_q + 3'd1;
            end
            OUT: begin
                y_out_d     = y_sat;
                out_valid_d = 1'b1;
                x2_d        = x1_q;
                x1_d        = x0_q;
                y2_d        = y1_q;
                y1_d        = y_sat;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tap_q       <= '0;
            acc_q       <= '0;
            x0_q        <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            y1_q        <= '0;
            y2_q        <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            b2_q        <= '0;
            a1_q        <= '0;
            a2_q        <= '0;
            y_out_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            acc_q       <= acc_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            y1_q        <= y1_d;
            y2_q        <= y2_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            b2_q        <= b2_d;
            a1_q        <= a1_d;
            a2_q        <= a2_d;
            y_out_q     <= y_out_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_iir_biquad_mac_sequencer.sv
// Bench for iir_biquad_mac_sequencer: table vectors, corner sequences and a random run
// against a behavioural biquad model; outputs are scoreboarded through a queue.
module tb_iir_biquad_mac_sequencer;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [3:0] x_in = '0, b0 = '0, b1 = '0, b2 = '0, a1 = '0, a2 = '0;
    logic signed [3:0] mul_a, mul_b;
    logic signed [7:0] mul_p;
    logic signed [3:0] y_out;
    logic              out_valid;
    logic              busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_q[$];
    int acc_cyc_q[$];
    int mx1 = 0, mx2 = 0, my1 = 0, my2 = 0;

    typedef struct {
        bit                rst_before;
        logic signed [3:0] b0, b1, b2, a1, a2, x, y;
    } vec_t;
    vec_t vecs[13];

    iir_biquad_mac_sequencer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
        .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2), .mul_a(mul_a), .mul_b(mul_b),
        .mul_p(mul_p), .y_out(y_out), .out_valid(out_valid), .busy(busy)
    );

    // External combinational multiplier.
    assign mul_p = 8'(mul_a) * 8'(mul_b);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                int e, a;
                e = exp_q.pop_front();
                a = acc_cyc_q.pop_front();
                chk("y_out", int'(y_out), e);
                chk("latency", cyc - a, 6);
            end
        end
    end

    function automatic int model_step(input int cb0, cb1, cb2, ca1, ca2, cx);
        int acc, q, y;
        acc = cb0 * cx + cb1 * mx1 + cb2 * mx2 - ca1 * my1 - ca2 * my2;
        q = acc >>> 2;
        y = (q > 7) ? 7 : ((q < -8) ? -8 : q);
        mx2 = mx1; mx1 = cx; my2 = my1; my1 = y;
        return y;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
    endtask

    task automatic send(input logic signed [3:0] cb0, cb1, cb2, ca1, ca2, cx,
                        input int expv, input bit detail);
        int n, w;
        @(negedge clk);
        b0 = cb0; b1 = cb1; b2 = cb2; a1 = ca1; a2 = ca2; x_in = cx; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(expv);
        acc_cyc_q.push_back(cyc + 1);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) begin
                in_valid = 1'b0;
                // Scramble inputs while busy; the sample in flight must not see this.
                x_in = 4'($urandom); b0 = 4'($urandom); b1 = 4'($urandom);
                b2 = 4'($urandom); a1 = 4'($urandom); a2 = 4'($urandom);
            end
            if (in_ready) break;
            if (detail && k < 5) begin
                chk($sformatf("mul_a_tap%0d", k), int'(mul_a), (k == 0) ? int'(cb0) : 0);
                chk($sformatf("mul_b_tap%0d", k), int'(mul_b), (k == 0) ? int'(cx) : 0);
            end
            n++;
        end
        chk("in_ready_low_cycles", n, 6);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 60) begin @(negedge clk); w++; end
        chk("drain_pending", exp_q.size(), 0);
        exp_q.delete();
        acc_cyc_q.delete();
    endtask

    initial begin
        int prev, cnt, ov;
        logic signed [3:0] r0, r1, r2, r3, r4, rx;

        vecs[0]  = '{1'b1, 4'sd4, 4'sd0, 4'sd0, 4'sd0,  4'sd0, 4'sd3,  4'sd3};
        vecs[1]  = '{1'b0, 4'sd4, 4'sd0, 4'sd0, 4'sd0,  4'sd0, -4'sd5, -4'sd5};
        vecs[2]  = '{1'b0, 4'sd4, 4'sd0, 4'sd0, 4'sd0,  4'sd0, 4'sd0,  4'sd0};
        vecs[3]  = '{1'b1, 4'sd0, 4'sd4, 4'sd0, 4'sd0,  4'sd0, 4'sd5,  4'sd0};
        vecs[4]  = '{1'b0, 4'sd0, 4'sd4, 4'sd0, 4'sd0,  4'sd0, -4'sd2, 4'sd5};
        vecs[5]  = '{1'b0, 4'sd0, 4'sd4, 4'sd0, 4'sd0,  4'sd0, 4'sd0,  -4'sd2};
        vecs[6]  = '{1'b1, 4'sd4, 4'sd0, 4'sd0, -4'sd2, 4'sd0, 4'sd4,  4'sd4};
        vecs[7]  = '{1'b0, 4'sd4, 4'sd0, 4'sd0, -4'sd2, 4'sd0, 4'sd0,  4'sd2};
        vecs[8]  = '{1'b0, 4'sd4, 4'sd0, 4'sd0, -4'sd2, 4'sd0, 4'sd0,  4'sd1};
        vecs[9]  = '{1'b0, 4'sd4, 4'sd0, 4'sd0, -4'sd2, 4'sd0, 4'sd0,  4'sd0};
        vecs[10] = '{1'b1, 4'sd7, 4'sd0, 4'sd0, 4'sd0,  4'sd0, 4'sd7,  4'sd7};
        vecs[11] = '{1'b0, 4'sd7, 4'sd0, 4'sd0, 4'sd0,  4'sd0, -4'sd8, -4'sd8};
        vecs[12] = '{1'b0, 4'sd7, 4'sd0, 4'sd0, 4'sd0,  4'sd0, 4'sd1,  4'sd1};

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_y_out", int'(y_out), 0);
        chk("rst_mul_a", int'(mul_a), 0);
        chk("rst_mul_b", int'(mul_b), 0);

        // Table vectors.
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].rst_before) do_reset();
            send(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].a1, vecs[i].a2, vecs[i].x,
                 int'(vecs[i].y), i == 0);
        end
        drain();

        // Continuous in_valid: one acceptance every 7 cycles.
        do_reset();
        @(negedge clk);
        b0 = 4'sd4; b1 = '0; b2 = '0; a1 = '0; a2 = '0; x_in = 4'sd2; in_valid = 1'b1;
        prev = -1; cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(2);
                acc_cyc_q.push_back(cyc + 1);
                if (prev >= 0) chk("accept_spacing", cyc + 1 - prev, 7);
                prev = cyc + 1;
                cnt++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("accept_count", cnt, 6);
        drain();

        // Abort during tap 2: no output, delay lines cleared (x1 held 2 before the abort).
        @(negedge clk);
        b0 = 4'sd4; b1 = 4'sd4; x_in = 4'sd5; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        ov = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) ov++;
        end
        chk("abort_no_out_valid", ov, 0);
        mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
        send(4'sd0, 4'sd4, 4'sd0, 4'sd0, 4'sd0, 4'sd6, 0, 1'b0);
        drain();

        // rst and in_valid together: sample is dropped.
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; b0 = 4'sd4; x_in = 4'sd3;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_wins_busy", int'(busy), 0);
        ov = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) ov++;
        end
        chk("rst_wins_no_out", ov, 0);

        // Random run against the behavioural model.
        do_reset();
        for (int i = 0; i < 24; i++) begin
            r0 = 4'($urandom); r1 = 4'($urandom); r2 = 4'($urandom);
            r3 = 4'($urandom); r4 = 4'($urandom); rx = 4'($urandom);
            send(r0, r1, r2, r3, r4, rx,
                 model_step(int'(r0), int'(r1), int'(r2), int'(r3), int'(r4), int'(rx)), 1'b0);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog_timeout actual=%0d expected=0", cyc);
        $fatal(1, "watchdog");
    end

endmodule
